// File: rtl/mem_responder.sv
// Purpose: 16-bit word-addressed RAM with fetch, data-read and data-write ports; optional post-reset clear sweep (MEM_CLEAR_EN).
// Latency: fetch and read data are registered, one cycle after the request; a same-cycle write to the same address is forwarded.
// Backpressure: none per request; all ports are ignored while ready=0 (reset and clear sweep).
module mem_responder #(
    parameter int          ADDR_W    = 12,
    parameter logic [15:0] CLEAR_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] fetch_addr,
    output logic [15:0] fetch_data,
    output logic        fetch_valid,
    input  logic        read_en,
    input  logic [15:0] read_addr,
    output logic [15:0] read_data,
    output logic        read_valid,
    input  logic        write_en,
    input  logic [15:0] write_addr,
    input  logic [15:0] write_data,
    output logic        ready
);

    localparam int DEPTH = 1 << ADDR_W;

    // An address is implemented only when every bit above ADDR_W is zero; no aliasing.
    function automatic logic addr_ok(input logic [15:0] a);
        return (a >> ADDR_W) == 16'h0000;
    endfunction

    logic [15:0]       mem [DEPTH];
    logic              wr_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [15:0]       mem_wd;
    logic [15:0]       fetch_next;
    logic [15:0]       read_next;

`ifdef MEM_CLEAR_EN
    localparam logic [0:0]        ST_CLEAR = 1'b0;
    localparam logic [0:0]        ST_RUN   = 1'b1;
    localparam logic [ADDR_W:0]   CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

    logic [0:0]      state;
    // One extra bit so the counter cannot wrap before the last address is written.
    logic [ADDR_W:0] clr_cnt;

    // Sweep sequencer: one location per cycle, RUN after the top address is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == CLR_LAST) begin
                state <= ST_RUN;
            end
        end
    end
`else
    localparam logic [0:0] ST_RUN = 1'b1;

    logic [0:0] state;

    // Without the sweep the responder goes straight to RUN after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end
    end
`endif

    // A user write is only taken once ready is up and the address is implemented.
    assign wr_acc = ready && write_en && addr_ok(write_addr);

    // Memory write-port mux: clear sweep has priority over user writes.
    always_comb begin
        mem_we = wr_acc;
        mem_wa = write_addr[ADDR_W-1:0];
        mem_wd = wr_acc ? write_data : CLEAR_VAL;
`ifdef MEM_CLEAR_EN
        if (state == ST_CLEAR && !rst) begin
            mem_we = 1'b1;
            mem_wa = clr_cnt[ADDR_W-1:0];
            mem_wd = CLEAR_VAL;
        end
`endif
    end

    // Storage array; deliberately not reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Next read values: out-of-range gives zero, same-address accepted write is forwarded.
    always_comb begin
        fetch_next = 16'h0000;
        read_next  = 16'h0000;
        if (addr_ok(fetch_addr)) begin
            fetch_next = (wr_acc && fetch_addr == write_addr) ? write_data
                                                              : mem[fetch_addr[ADDR_W-1:0]];
        end
        if (addr_ok(read_addr)) begin
            read_next = (wr_acc && read_addr == write_addr) ? write_data
                                                            : mem[read_addr[ADDR_W-1:0]];
        end
    end

    // Output registers: ready follows state one edge later; data holds when not serviced.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready       <= 1'b0;
            fetch_data  <= 16'h0000;
            fetch_valid <= 1'b0;
            read_data   <= 16'h0000;
            read_valid  <= 1'b0;
        end else begin
            ready       <= (state == ST_RUN);
            fetch_valid <= ready;
            read_valid  <= ready && read_en;
            if (ready) begin
                fetch_data <= fetch_next;
            end
            if (ready && read_en) begin
                read_data <= read_next;
            end
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Responder end of the CPU memory interface: a synchronous 16-bit word-addressed RAM.
- Serves three ports at once:
  - instruction fetch (read-only, driven by pc);
  - data read;
  - data write.
- Sits beside the CPU core as the target of its fetch and load/store requests.
- Registered reads, write forwarding, and a post-reset clear sweep gated by a ready flag.

Parameters:
- ADDR_W, 12, number of implemented address bits; depth is 2^ADDR_W words.
- CLEAR_VAL, 16'h0000, word written to every location during the clear sweep.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- fetch_addr  input  16  instruction fetch address (word).
- fetch_data  output  16  fetched instruction, registered.
- fetch_valid  output  1  fetch_data corresponds to fetch_addr of previous cycle.
- read_en  input  1  data read request.
- read_addr  input  16  data read address.
- read_data  output  16  data read result, registered.
- read_valid  output  1  read_data holds result of request accepted previous cycle.
- write_en  input  1  data write request.
- write_addr  input  16  data write address.
- write_data  input  16  data write value.
- ready  output  1  high when requests are accepted (state RUN).

Behaviour:
- Reset (rst=1 at edge):
  - fetch_data=0, fetch_valid=0, read_data=0, read_valid=0, ready=0.
  - Clear counter = 0; state = CLEAR if MEM_CLEAR_EN is defined, else RUN.
  - rst asserted in any state, including mid-sweep, restarts from this point.
- States:
  - CLEAR: each cycle writes CLEAR_VAL to address counter, then counter+1. The cycle writing address 2^ADDR_W-1 transitions to RUN. Counter is ADDR_W+1 bits, so there is no early wrap.
  - RUN: steady state; ready=1; never leaves except via rst.
- While ready=0:
  - write_en ignored;
  - read_en and fetch are not serviced;
  - fetch_valid=0, read_valid=0, data outputs hold their previous values.
- Fetch in RUN:
  - every cycle, fetch_data <= mem[fetch_addr]; fetch_valid <= 1.
  - Latency is 1 cycle; no enable.
- Data read in RUN:
  - read_en=1 gives read_data <= mem[read_addr], read_valid <= 1.
  - read_en=0 gives read_valid <= 0 and read_data holds.
- Write in RUN: write_en=1 gives mem[write_addr] <= write_data at the edge.
- Read-during-write, same cycle and same in-range address: the read port and/or fetch port return write_data (new data), not the old contents.
- Address range:
  - An address is in range when bits [15:ADDR_W] are all zero.
  - Out-of-range reads and fetches return 16'h0000 with valid still asserted.
  - Out-of-range writes are dropped.
  - No aliasing or wrap-around.
- Simultaneous fetch, read and write to the same address: both read ports see the forwarded write_data.
- Widths: all data paths are 16 bits; no sign or width conversion.

Optional Feature:
- MEM_CLEAR_EN defined:
  - the CLEAR sweep runs after every reset;
  - ready rises exactly 2^ADDR_W+1 edges after the reset edge, i.e. 2^ADDR_W sweep edges after the reset edge, plus the edge that sets ready.
- MEM_CLEAR_EN undefined:
  - no sweep and no clear counter;
  - ready=1 at the first edge after rst deasserts;
  - memory contents are uninitialised (X in simulation) until written.

Test Plan:
- Clear sweep (MEM_CLEAR_EN, ADDR_W=4): pulse rst 1 cycle, then idle.
  - Required: ready stays 0 for 16 edges after the reset edge, rises on the 17th edge.
  - Then read addr 0..15 → every read_data=0x0000, read_valid=1.
- Basic write/read:
  - Cycle 0: write 0x1234 to 0x0005.
  - Cycle 1: read_en at 0x0005 → cycle 2 read_data=0x1234, read_valid=1.
  - Cycle 2: read_en=0 → cycle 3 read_valid=0, read_data still 0x1234.
- Forwarding:
  - Same cycle: write 0xBEEF to 0x0003, read_en at 0x0003, fetch_addr=0x0003.
  - Required next cycle: read_data=0xBEEF and fetch_data=0xBEEF.
- Out-of-range (ADDR_W=4):
  - Write 0xAAAA to 0x0013, then read 0x0003 → prior contents unchanged (0x0000 after clear).
  - Read 0x0013 → 0x0000 with read_valid=1.
- Reset mid-sweep: assert rst at sweep count 7 → ready stays 0; a full 16-edge sweep restarts; ready rises on the 17th edge after the new reset edge.
- Fetch streaming: preload 0x0000..0x0003 with 0x1000..0x1003, drive fetch_addr 0,1,2,3 on consecutive cycles → fetch_data 0x1000..0x1003 one cycle later each, with fetch_valid=1 throughout.
